// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: drives the instruction ROM address, pairs the returned
// word with its PC and presents it to decode over a valid/ready handshake.
// Supports decode back-pressure and branch/jump redirect with squash.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      out_imem_addr,
  input  logic [31:0]      in_imem_rdata,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_valid,
  input  logic             in_ready,
  input  logic             in_redirect,
  input  logic [31:0]      in_redirect_target,
  output logic [CNT_W-1:0] out_fetch_count,
  output logic [CNT_W-1:0] out_stall_count
);

  localparam int unsigned PC_W      = 32;
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
  localparam logic [PC_W-1:0] WORD_MSK = ~PC_W'(3);

  // PC whose instruction is currently on in_imem_rdata, and its valid flag
  logic [PC_W-1:0]  pc_q;
  logic             vld_q;
  logic [PC_W-1:0]  next_pc_c;
  logic             accept_c;
  logic             stall_c;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Next fetch address: redirect wins, then fill/hold, else sequential
  always_comb begin
    next_pc_c = pc_q;
    if (in_redirect) begin
      next_pc_c = in_redirect_target & WORD_MSK;
    end else if (!vld_q) begin
      next_pc_c = pc_q;
    end else if (!in_ready) begin
      next_pc_c = pc_q;
    end else begin
      next_pc_c = pc_q + PC_STEP;
    end
  end

  // Handshake qualifiers; a redirecting cycle counts neither as accept nor stall
  always_comb begin
    accept_c = vld_q && in_ready && !in_redirect;
    stall_c  = vld_q && !in_ready && !in_redirect;
  end

  // PC and valid registers; ROM re-reads pc_q on hold so the output stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      vld_q <= 1'b0;
    end else begin
      pc_q  <= next_pc_c;
      vld_q <= 1'b1;
    end
  end

  // Performance counters, free-running modulo 2^CNT_W, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept_c) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (stall_c) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output mapping; the instruction passes straight through from the ROM
  always_comb begin
    out_imem_addr   = next_pc_c;
    out_instr       = in_imem_rdata;
    out_pc          = pc_q;
    out_valid       = vld_q && !in_redirect;
    out_fetch_count = fetch_cnt_q;
    out_stall_count = stall_cnt_q;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of instruction_fetch, the synchronous 1-cycle-latency instruction ROM. It generates the word address presented to instruction_fetch each cycle. It pairs the returned instruction with its PC and hands the pair to decode over a valid/ready handshake. Decode/execute can stall it, and a branch/jump can redirect it; wrong-path fetches are squashed.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
CNT_W, 32, width of fetched-instruction and stall counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
out_imem_addr  output  32  combinational fetch address to instruction_fetch read_address
in_imem_rdata  input  32  instruction from instruction_fetch; holds mem[address sampled at previous edge]
out_instr  output  32  instruction to decode (= in_imem_rdata)
out_pc  output  32  PC of out_instr
out_valid  output  1  out_instr/out_pc valid
in_ready  input  1  decode accepts this cycle
in_redirect  input  1  branch/jump taken; squash current output and refetch
in_redirect_target  input  32  redirect PC; bits [1:0] forced to 0
out_fetch_count  output  CNT_W  count of accepted instructions (valid && ready && !redirect)
out_stall_count  output  CNT_W  cycles with valid && !ready && !redirect

Behaviour:
- Registers: pc_q (PC whose instruction is on in_imem_rdata), vld_q, two counters.
- Async reset: pc_q=RESET_PC, vld_q=0, counters=0. Hence out_valid=0, out_pc=RESET_PC, out_imem_addr=RESET_PC while rst=1 and during the first cycle after release.
- out_valid = vld_q && !in_redirect. out_pc = pc_q. out_instr = in_imem_rdata. No extra latency.
- next_pc (= out_imem_addr), priority order:
  1. in_redirect: {in_redirect_target[31:2],2'b00}
  2. !vld_q: pc_q (startup fill)
  3. vld_q && !in_ready: pc_q (hold; ROM re-reads same word, so output stays stable)
  4. vld_q && in_ready: pc_q + 4
- Every edge (rst=0): pc_q <= next_pc; vld_q <= 1.
- Startup latency: first valid instruction (PC=RESET_PC) appears 1 cycle after reset release; then 1 instr/cycle while in_ready=1.
- Stall rule: while out_valid && !in_ready, out_pc and out_instr must hold constant every cycle.
- Redirect: the instruction currently presented is discarded, not counted. The target instruction is valid on the next cycle, regardless of in_ready. Redirect during stall, or during the startup cycle, behaves identically.
- Redirect target with nonzero [1:0]: low bits dropped silently; no fault raised.
- PC arithmetic: 32-bit modulo. 0xFFFF_FFFC + 4 = 0x0000_0000. The ROM indexes by address [11:2], so fetches alias every 4 KiB; this is intentional.
- Counters: saturate-free 2^CNT_W wrap. Both are cleared only by rst.
- Reset asserted mid-stream: immediate return to reset values; any in-flight fetch is lost.
- in_ready and in_redirect are combinational paths to out_imem_addr. Drivers must be settled before the clock edge.

Test Plan:
- Reset release, in_ready=1, ROM word i = 0x1000_0000+i -> cycle0 out_valid=0, addr=0. Cycle1: valid, pc=0x0, instr=0x1000_0000. Cycle2: pc=0x4, instr=0x1000_0001. fetch_count=2 after cycle2.
- Stall at pc=0x8 for 3 cycles (in_ready=0) -> out_pc=0x8, instr=0x1000_0002 held all 3 cycles, addr=0x8, stall_count=3. Release -> next cycle pc=0xC.
- Redirect at pc=0x10 with target 0x40 -> that cycle out_valid=0, addr=0x40, fetch_count unchanged. Next cycle pc=0x40, instr=0x1000_0010.
- Redirect target 0x43 while in_ready=0 -> next cycle pc=0x40, valid=1. Redirect asserted in the startup cycle -> first valid pc is the target, not RESET_PC.
- RESET_PC=0xFFFF_FFF8, in_ready=1 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, instr = ROM words 1022, 1023, 0.
- Assert rst asynchronously mid-stall -> out_valid drops in the same cycle without a clock edge. Counters=0, addr=RESET_PC. Normal startup resumes after release.
